// File: rtl/serial_deframer.sv
// serial_deframer
//   Receive-side serial-to-parallel stage. Reassembles LSB-first words from a
//   single-bit stream aligned by a word-start marker. Completed words are
//   offered through a one-entry holding register with a valid/ready handshake.
//
// Ports
//   clk         clock, all logic on the rising edge
//   resetn      synchronous active-low reset
//   sin         serial data bit, LSB of each word first
//   frame       high in the cycle where sin carries bit 0 of a new word
//   dout        held word, meaningful while dout_valid is high
//   dout_valid  holding register contains an untransferred word
//   dout_ready  consumer accepts dout on an edge where dout_valid is high
//   busy        a word is partially assembled
//   overflow    one-cycle pulse: completed word dropped, holding register full
//   resync      one-cycle pulse: frame arrived mid-word, partial word dropped
module serial_deframer #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  sin,
    input  logic                  frame,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  busy,
    output logic                  overflow,
    output logic                  resync
);

    localparam int unsigned    CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    valid_q, valid_d;
    logic                    overflow_q, overflow_d;
    logic                    resync_q, resync_d;
    logic                    complete;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        dout_d     = dout_q;
        valid_d    = valid_q;
        overflow_d = 1'b0;
        resync_d   = 1'b0;
        complete   = 1'b0;

        case (state_q)
            IDLE: begin
                if (frame) begin
                    shreg_d    = '0;
                    shreg_d[0] = sin;
                    cnt_d      = CW'(1);
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (frame) begin
                    // A new marker wins even on the final bit: restart the word.
                    resync_d   = 1'b1;
                    shreg_d    = '0;
                    shreg_d[0] = sin;
                    cnt_d      = CW'(1);
                end else begin
                    shreg_d[cnt_q] = sin;
                    if (cnt_q == LAST) begin
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Holding register: a drain and a load may share the same edge.
        if (complete) begin
            if (!valid_q || dout_ready) begin
                dout_d  = shreg_d;
                valid_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shreg_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q == SHIFT);
    assign overflow   = overflow_q;
    assign resync     = resync_q;

endmodule
